snake_ctrl: RTL and testbench
=============================

SNAKE_CTRL -- requirements
Module: snake_ctrl

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 24'd12500000, meaning the number of enb-qualified clk cycles per snake move.
REQ-002 SHALL have parameter H_LOGIC_MAX, default 5'd31, meaning the last grid column.
REQ-003 SHALL have parameter V_LOGIC_MAX, default 5'd23, meaning the last grid row.
REQ-004 SHALL have parameters DIR_UP 2'b00, DIR_DOWN 2'b11, DIR_LEFT 2'b10, DIR_RIGHT 2'b01; the reverse of any direction is its bitwise complement.
REQ-005 SHALL have ports, in this order:
  clk  in  1  clock
  rst  in  1  reset; synchronous, active-high
  enb  in  1  game advance enable
  start  in  1  start or restart request
  dir_req  in  2  requested direction
  dir_req_vld  in  1  dir_req qualifier
  headx/heady  in  5/5  current head cell from the snake body
  tailx/taily  in  5/5  current tail cell from the snake body
  foodx/foody  in  5/5  food cell
  qx/qy  in  5/5  renderer occupancy query
  direction  out  2  committed move direction
  valid  out  1  one-cycle move strobe
  score  out  1  move eats food, qualified by valid
  game_over  out  1  collision latched
  qhit  out  1  occupancy of (qx,qy), 1-cycle latency

Function
REQ-006 SHALL hold an occupancy map of (V_LOGIC_MAX+1) rows by (H_LOGIC_MAX+1) bits.
REQ-007 SHALL implement states IDLE, RUN, CHECK, OVER.
REQ-008 IDLE: on start=1, set the map cells at (headx,heady) and (tailx,taily), load tail_q with {tailx,taily}, clear the tick counter, and go to RUN.
REQ-009 SHALL keep pending_dir: on dir_req_vld in IDLE/RUN/CHECK, pending_dir <= dir_req unless dir_req == ~direction; a rejected request is dropped.
REQ-010 RUN: when enb=1, the tick counter SHALL increment; at TICK_CYCLES-1 it SHALL wrap to 0 and the FSM SHALL go to CHECK; enb=0 freezes the counter.
REQ-011 On entering CHECK, SHALL register next cell (nx,ny) from head and pending_dir.
  - Wrap rule: 0-1 -> MAX and MAX+1 -> 0, per axis.
  - Only the moving axis changes.
REQ-012 CHECK lasts one cycle and is not gated by enb.
  - eat = (nx,ny)==(foodx,foody).
  - hit = map[ny][nx] & ~(((nx,ny)==(tailx,taily)) & ~eat).
REQ-013 CHECK with hit=1: go to OVER, game_over <= 1, valid stays 0.
REQ-014 CHECK with hit=0:
  - valid=1 for exactly one cycle, with direction <= pending_dir and score <= eat in that same cycle.
  - Set map[ny][nx].
  - Return to RUN.
REQ-015 score and valid SHALL be 0 in every other cycle.
REQ-016 In RUN/CHECK, whenever {tailx,taily} != tail_q, SHALL clear map at tail_q and load tail_q <= {tailx,taily}.
  - If a set and a clear target the same cell in one cycle, the set wins.
REQ-017 OVER: hold the map, direction and game_over; ignore dir_req; on start=1, clear the whole map and game_over in one cycle and go to IDLE.
REQ-018 qhit SHALL be registered as map[qy][qx] every cycle in all states; qy>V_LOGIC_MAX gives qhit=0.

Reset
REQ-019 rst SHALL force:
  - state IDLE, map all zero, tick counter 0, tail_q 0;
  - direction = pending_dir = DIR_RIGHT;
  - valid, score, game_over, qhit = 0.
REQ-020 rst mid-move (RUN or CHECK) SHALL abort the move with no valid pulse.

Verification
REQ-021 TICK_CYCLES=4, head (5,5), tail (4,5), start, enb=1 -> valid pulses every 5 cycles (4 RUN + 1 CHECK), direction=01, score=0.
REQ-022 Head (31,5), pending DIR_RIGHT -> CHECK next cell (0,5); head (3,0) with DIR_UP -> (3,23).
REQ-023 direction=DIR_RIGHT, dir_req=DIR_LEFT with dir_req_vld -> request ignored; dir_req=DIR_UP -> next valid carries direction=00.
REQ-024 Food at (6,5), head (5,5) moving right -> valid=1 with score=1 in the same cycle; the tail cell is not cleared that move.
REQ-025 Occupied cell at next head, not the tail -> game_over=1, no valid; start -> map cleared, back to IDLE; then a query of a prior cell -> qhit=0 one cycle later.
REQ-026 enb=0 for 100 cycles mid-count -> no valid; count resumes from its held value when enb returns.

Source files
------------

// File: rtl/snake_ctrl.sv
// snake_ctrl
// Game controller for a grid snake. It paces head moves with an
// enb-qualified tick counter, arbitrates direction requests, keeps a one-bit
// occupancy map of the snake body, detects self-collision and answers
// single-cell occupancy queries from the renderer.
//
// The body itself (head/tail positions) lives outside this block. On each
// committed move the controller pulses valid and reports the new direction
// and whether food was eaten. The body logic then presents its updated
// head/tail. Whenever the presented tail moves away from the last tail seen
// here, the old tail cell is released from the map.

module snake_ctrl #(
    parameter logic [23:0] TICK_CYCLES = 24'd12500000,
    parameter logic [4:0]  H_LOGIC_MAX = 5'd31,
    parameter logic [4:0]  V_LOGIC_MAX = 5'd23,
    parameter logic [1:0]  DIR_UP      = 2'b00,
    parameter logic [1:0]  DIR_DOWN    = 2'b11,
    parameter logic [1:0]  DIR_LEFT    = 2'b10,
    parameter logic [1:0]  DIR_RIGHT   = 2'b01
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enb,
    input  logic       start,
    input  logic [1:0] dir_req,
    input  logic       dir_req_vld,
    input  logic [4:0] headx,
    input  logic [4:0] heady,
    input  logic [4:0] tailx,
    input  logic [4:0] taily,
    input  logic [4:0] foodx,
    input  logic [4:0] foody,
    input  logic [4:0] qx,
    input  logic [4:0] qy,
    output logic [1:0] direction,
    output logic       valid,
    output logic       score,
    output logic       game_over,
    output logic       qhit
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_CHECK = 2'd2,
        S_OVER  = 2'd3
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e               state_q;
    logic [H_LOGIC_MAX:0] map_q [0:V_LOGIC_MAX];  // one row per grid line
    logic [23:0]          tick_q;
    logic [9:0]           tail_q;                 // {x, y} of last tail seen
    logic [4:0]           nx_q;                   // candidate head cell,
    logic [4:0]           ny_q;                   // captured on entry to CHECK
    logic [1:0]           direction_q;
    logic [1:0]           pending_q;
    logic                 valid_q;
    logic                 score_q;
    logic                 game_over_q;
    logic                 qhit_q;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [4:0] nx_d;
    logic [4:0] ny_d;
    logic       qhit_d;
    logic       next_occupied;
    logic       next_is_tail;
    logic       eat;
    logic       hit;
    logic       tail_moved;
    logic       tick_last;
    logic       dir_accept;

    // True when (x, y) addresses a real map cell. Zero-extending both sides
    // keeps the compare meaningful whatever the grid size parameters are.
    function automatic logic in_grid(input logic [4:0] x, input logic [4:0] y);
        return ({1'b0, x} <= {1'b0, H_LOGIC_MAX}) &&
               ({1'b0, y} <= {1'b0, V_LOGIC_MAX});
    endfunction

    // Next head cell: step the head one cell along pending_q, wrapping at each edge.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no
        // branch can leave it unassigned and infer a latch.
        nx_d = headx;
        ny_d = heady;
        case (pending_q)
            DIR_UP:    ny_d = (heady == 5'd0)        ? V_LOGIC_MAX : heady - 5'd1;
            DIR_DOWN:  ny_d = (heady == V_LOGIC_MAX) ? 5'd0        : heady + 5'd1;
            DIR_LEFT:  nx_d = (headx == 5'd0)        ? H_LOGIC_MAX : headx - 5'd1;
            DIR_RIGHT: nx_d = (headx == H_LOGIC_MAX) ? 5'd0        : headx + 5'd1;
            default: begin
                nx_d = headx;
                ny_d = heady;
            end
        endcase
    end

    // Move decisions for the CHECK cycle, tail tracking, direction filter, query read.
    always_comb begin
        next_occupied = 1'b0;
        if (in_grid(nx_q, ny_q)) begin
            next_occupied = map_q[ny_q][nx_q];
        end

        eat          = (nx_q == foodx) && (ny_q == foody);
        next_is_tail = (nx_q == tailx) && (ny_q == taily);
        // Stepping onto the tail is legal on a non-eating move, because the
        // tail vacates that cell during the same move.
        hit          = next_occupied & ~(next_is_tail & ~eat);

        tail_moved   = ({tailx, taily} != tail_q);
        tick_last    = (tick_q == TICK_CYCLES - 24'd1);

        // A request for the exact reverse of the committed direction would
        // fold the snake onto itself; it is dropped rather than queued.
        dir_accept   = dir_req_vld && (dir_req != ~direction_q);

        qhit_d = 1'b0;
        if (in_grid(qx, qy)) begin
            qhit_d = map_q[qy][qx];
        end
    end

    // Game FSM with the occupancy map, tick counter and all registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is only ever written with non-blocking
        // assignments; when two writes hit the same map cell in one cycle
        // the later statement in this block takes effect.
        if (rst) begin
            state_q     <= S_IDLE;
            // NOTE: the map is a bank of flops rather than a RAM, so it can
            // be wiped in a single cycle, both here and on restart from OVER.
            for (int r = 0; r <= int'(V_LOGIC_MAX); r++) begin
                map_q[r] <= '0;
            end
            tick_q      <= '0;
            tail_q      <= '0;
            nx_q        <= '0;
            ny_q        <= '0;
            direction_q <= DIR_RIGHT;
            pending_q   <= DIR_RIGHT;
            valid_q     <= 1'b0;
            score_q     <= 1'b0;
            game_over_q <= 1'b0;
            qhit_q      <= 1'b0;
        end else begin
            // Move strobes are single-cycle; only a clean CHECK raises them.
            valid_q <= 1'b0;
            score_q <= 1'b0;
            qhit_q  <= qhit_d;

            if (state_q != S_OVER && dir_accept) begin
                pending_q <= dir_req;
            end

            // Release the old tail cell as soon as the body reports a new tail.
            // This sits above the CHECK head write so that a head landing on
            // the departing tail cell keeps the cell occupied.
            if ((state_q == S_RUN || state_q == S_CHECK) && tail_moved) begin
                if (in_grid(tail_q[9:5], tail_q[4:0])) begin
                    map_q[tail_q[4:0]][tail_q[9:5]] <= 1'b0;
                end
                tail_q <= {tailx, taily};
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (in_grid(headx, heady)) begin
                            map_q[heady][headx] <= 1'b1;
                        end
                        if (in_grid(tailx, taily)) begin
                            map_q[taily][tailx] <= 1'b1;
                        end
                        tail_q  <= {tailx, taily};
                        tick_q  <= '0;
                        state_q <= S_RUN;
                    end
                end

                S_RUN: begin
                    // enb low simply freezes the count where it is.
                    if (enb) begin
                        if (tick_last) begin
                            tick_q  <= '0;
                            nx_q    <= nx_d;
                            ny_q    <= ny_d;
                            state_q <= S_CHECK;
                        end else begin
                            tick_q <= tick_q + 24'd1;
                        end
                    end
                end

                S_CHECK: begin
                    // Single-cycle decision, deliberately not gated by enb.
                    if (hit) begin
                        game_over_q <= 1'b1;
                        state_q     <= S_OVER;
                    end else begin
                        valid_q     <= 1'b1;
                        score_q     <= eat;
                        direction_q <= pending_q;
                        if (in_grid(nx_q, ny_q)) begin
                            map_q[ny_q][nx_q] <= 1'b1;
                        end
                        state_q     <= S_RUN;
                    end
                end

                S_OVER: begin
                    // Frozen until restart; the final board stays visible
                    // through qhit.
                    if (start) begin
                        for (int r = 0; r <= int'(V_LOGIC_MAX); r++) begin
                            map_q[r] <= '0;
                        end
                        game_over_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign direction = direction_q;
    assign valid     = valid_q;
    assign score     = score_q;
    assign game_over = game_over_q;
    assign qhit      = qhit_q;

endmodule

// File: tb/tb_snake_ctrl.sv
// tb_snake_ctrl
// Self-checking bench for snake_ctrl. A behavioural reference model (plain
// integer grid arithmetic over a 2-D bit array) predicts every output each
// cycle. A queue-based snake body plays the part of the external body logic.
// Directed scenarios cover the headline behaviours, then a randomized game
// session runs against the same model.

module tb_snake_ctrl;

    localparam int TICK  = 4;
    localparam int COLS  = 32;
    localparam int ROWS  = 24;

    localparam int P_IDLE  = 0;
    localparam int P_RUN   = 1;
    localparam int P_CHECK = 2;
    localparam int P_OVER  = 3;

    localparam logic [1:0] UP    = 2'b00;
    localparam logic [1:0] DOWN  = 2'b11;
    localparam logic [1:0] LEFT  = 2'b10;
    localparam logic [1:0] RIGHT = 2'b01;

    logic       clk;
    logic       rst;
    logic       enb;
    logic       start;
    logic [1:0] dir_req;
    logic       dir_req_vld;
    logic [4:0] headx, heady, tailx, taily, foodx, foody, qx, qy;
    logic [1:0] direction;
    logic       valid, score, game_over, qhit;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int         m_phase;
    bit         m_map [ROWS][COLS];
    int         m_tick;
    int         m_tx, m_ty;
    int         m_nx, m_ny;
    logic [1:0] m_dir, m_pend;
    bit         m_valid, m_score, m_go, m_qhit;

    // External snake body, head at index 0
    int body_x[$];
    int body_y[$];

    snake_ctrl #(.TICK_CYCLES(24'(TICK))) dut (
        .clk         (clk),
        .rst         (rst),
        .enb         (enb),
        .start       (start),
        .dir_req     (dir_req),
        .dir_req_vld (dir_req_vld),
        .headx       (headx),
        .heady       (heady),
        .tailx       (tailx),
        .taily       (taily),
        .foodx       (foodx),
        .foody       (foody),
        .qx          (qx),
        .qy          (qy),
        .direction   (direction),
        .valid       (valid),
        .score       (score),
        .game_over   (game_over),
        .qhit        (qhit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int dx(input logic [1:0] d);
        case (d)
            LEFT:    return -1;
            RIGHT:   return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int dy(input logic [1:0] d);
        case (d)
            UP:      return -1;
            DOWN:    return 1;
            default: return 0;
        endcase
    endfunction

    // Two directions are reverses when their step vectors cancel.
    function automatic bit is_reverse(input logic [1:0] a, input logic [1:0] b);
        return (dx(a) == -dx(b)) && (dy(a) == -dy(b));
    endfunction

    function automatic void clear_model_map();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                m_map[r][c] = 1'b0;
    endfunction

    // Advance the reference model by one clock, using the inputs the DUT sees.
    task automatic model_step();
        int         hx, hy, tx, ty, fx, fy;
        bit         q_read, eat, occ, hit;
        logic [1:0] old_pend;
        if (rst) begin
            m_phase = P_IDLE;
            clear_model_map();
            m_tick  = 0;
            m_tx    = 0;
            m_ty    = 0;
            m_dir   = RIGHT;
            m_pend  = RIGHT;
            m_valid = 1'b0;
            m_score = 1'b0;
            m_go    = 1'b0;
            m_qhit  = 1'b0;
            return;
        end
        hx = int'(headx); hy = int'(heady);
        tx = int'(tailx); ty = int'(taily);
        fx = int'(foodx); fy = int'(foody);

        // Everything read from the map uses its value before this edge.
        q_read   = (int'(qy) < ROWS) ? m_map[qy][qx] : 1'b0;
        eat      = (m_nx == fx) && (m_ny == fy);
        occ      = m_map[m_ny][m_nx];
        hit      = occ && !((m_nx == tx) && (m_ny == ty) && !eat);
        old_pend = m_pend;

        m_valid = 1'b0;
        m_score = 1'b0;
        m_qhit  = q_read;

        if (m_phase != P_OVER && dir_req_vld && !is_reverse(dir_req, m_dir))
            m_pend = dir_req;

        // Tail release first, so a head write to the same cell wins.
        if ((m_phase == P_RUN || m_phase == P_CHECK) && (tx != m_tx || ty != m_ty)) begin
            m_map[m_ty][m_tx] = 1'b0;
            m_tx = tx;
            m_ty = ty;
        end

        case (m_phase)
            P_IDLE: if (start) begin
                m_map[hy][hx] = 1'b1;
                m_map[ty][tx] = 1'b1;
                m_tx    = tx;
                m_ty    = ty;
                m_tick  = 0;
                m_phase = P_RUN;
            end
            P_RUN: if (enb) begin
                if (m_tick == TICK - 1) begin
                    m_tick  = 0;
                    m_nx    = (hx + dx(old_pend) + COLS) % COLS;
                    m_ny    = (hy + dy(old_pend) + ROWS) % ROWS;
                    m_phase = P_CHECK;
                end else begin
                    m_tick++;
                end
            end
            P_CHECK: begin
                if (hit) begin
                    m_go    = 1'b1;
                    m_phase = P_OVER;
                end else begin
                    m_valid = 1'b1;
                    m_score = eat;
                    m_dir   = old_pend;
                    m_map[m_ny][m_nx] = 1'b1;
                    m_phase = P_RUN;
                end
            end
            default: if (start) begin
                clear_model_map();
                m_go    = 1'b0;
                m_phase = P_IDLE;
            end
        endcase
    endtask

    // Fresh two-cell snake with head (x,y) and tail one step behind along d.
    task automatic new_body(input int x, input int y, input logic [1:0] d);
        body_x.delete();
        body_y.delete();
        body_x.push_back(x);
        body_y.push_back(y);
        body_x.push_back((x - dx(d) + COLS) % COLS);
        body_y.push_back((y - dy(d) + ROWS) % ROWS);
    endtask

    // One clock: present body, clock model and DUT, compare at the falling
    // edge, then let the body follow the predicted move.
    task automatic cycle();
        headx = 5'(body_x[0]);
        heady = 5'(body_y[0]);
        tailx = 5'(body_x[body_x.size() - 1]);
        taily = 5'(body_y[body_y.size() - 1]);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("valid",     32'(valid),     32'(m_valid));
        check("score",     32'(score),     32'(m_score));
        check("game_over", 32'(game_over), 32'(m_go));
        check("direction", 32'(direction), 32'(m_dir));
        check("qhit",      32'(qhit),      32'(m_qhit));
        if (m_valid) begin
            body_x.push_front(m_nx);
            body_y.push_front(m_ny);
            if (!m_score) begin
                void'(body_x.pop_back());
                void'(body_y.pop_back());
            end
        end
    endtask

    // Run cycles until the DUT shows valid (or game_over); bounded.
    task automatic wait_move(input int limit, input bit want_over, output int n);
        bit seen;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < limit) begin
            cycle();
            n++;
            seen = want_over ? game_over : valid;
        end
        check(want_over ? "wait_game_over" : "wait_valid", 32'(seen), 32'd1);
    endtask

    task automatic pulse_dir(input logic [1:0] d);
        dir_req     = d;
        dir_req_vld = 1'b1;
        cycle();
        dir_req_vld = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic press_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic food_at(input int x, input int y);
        foodx = 5'(x);
        foody = 5'(y);
    endtask

    task automatic food_ahead();
        food_at((body_x[0] + dx(m_pend) + COLS) % COLS,
                (body_y[0] + dy(m_pend) + ROWS) % ROWS);
    endtask

    initial begin
        int n, vc, tx, ty;

        rst = 1'b0; enb = 1'b1; start = 1'b0;
        dir_req = RIGHT; dir_req_vld = 1'b0;
        qx = 5'd5; qy = 5'd5;
        food_at(20, 20);
        new_body(5, 5, RIGHT);

        // Reset state
        do_reset();
        check("rst_direction", 32'(direction), 32'(RIGHT));
        check("rst_valid",     32'(valid),     32'd0);
        check("rst_score",     32'(score),     32'd0);
        check("rst_game_over", 32'(game_over), 32'd0);
        check("rst_qhit",      32'(qhit),      32'd0);

        // Move cadence: 4 RUN cycles + 1 CHECK
        press_start();
        wait_move(50, 1'b0, n);
        check("first_move_latency", n, 5);
        check("first_move_dir", 32'(direction), 32'(RIGHT));
        check("first_move_score", 32'(score), 32'd0);
        wait_move(50, 1'b0, n);
        check("move_period", n, 5);
        qx = 5'd7; qy = 5'd5;
        cycle();
        check("head_cell_occupied", 32'(qhit), 32'd1);
        qx = 5'd5; qy = 5'd5;
        cycle();
        check("old_tail_released", 32'(qhit), 32'd0);

        // Reverse request dropped, perpendicular request taken
        pulse_dir(LEFT);
        wait_move(50, 1'b0, n);
        check("reverse_ignored", 32'(direction), 32'(RIGHT));
        pulse_dir(UP);
        wait_move(50, 1'b0, n);
        check("turn_up", 32'(direction), 32'(UP));
        pulse_dir(RIGHT);
        wait_move(50, 1'b0, n);
        check("turn_right", 32'(direction), 32'(RIGHT));

        // Eating: score with valid, tail cell kept
        food_ahead();
        tx = body_x[body_x.size() - 1];
        ty = body_y[body_y.size() - 1];
        wait_move(50, 1'b0, n);
        check("eat_score", 32'(score), 32'd1);
        food_at(20, 20);
        qx = 5'(tx); qy = 5'(ty);
        cycle();
        check("tail_kept_on_eat", 32'(qhit), 32'd1);

        // Horizontal wrap: (31,5) right -> (0,5)
        do_reset();
        new_body(31, 5, RIGHT);
        press_start();
        wait_move(50, 1'b0, n);
        qx = 5'd0; qy = 5'd5;
        cycle();
        check("wrap_right_cell", 32'(qhit), 32'd1);

        // Vertical wrap: (3,0) up -> (3,23)
        do_reset();
        pulse_dir(UP);
        new_body(3, 0, UP);
        press_start();
        wait_move(50, 1'b0, n);
        check("wrap_up_dir", 32'(direction), 32'(UP));
        qx = 5'd3; qy = 5'd23;
        cycle();
        check("wrap_up_cell", 32'(qhit), 32'd1);
        qx = 5'd3; qy = 5'd30;
        cycle();
        check("query_row_out_of_range", 32'(qhit), 32'd0);

        // Self collision: grow to 5 cells, then curl back into the body
        do_reset();
        food_at(6, 5);
        new_body(5, 5, RIGHT);
        press_start();
        wait_move(50, 1'b0, n);
        check("grow1_score", 32'(score), 32'd1);
        food_at(7, 5);
        wait_move(50, 1'b0, n);
        food_at(8, 5);
        wait_move(50, 1'b0, n);
        food_at(20, 20);
        check("grown_length", body_x.size(), 5);
        pulse_dir(UP);
        wait_move(50, 1'b0, n);
        pulse_dir(LEFT);
        wait_move(50, 1'b0, n);
        pulse_dir(DOWN);
        wait_move(50, 1'b1, n);
        check("collision_no_valid", 32'(valid), 32'd0);
        check("collision_game_over", 32'(game_over), 32'd1);
        qx = 5'd7; qy = 5'd4;
        vc = 0;
        repeat (10) begin
            cycle();
            vc += int'(valid);
        end
        check("over_no_valid", vc, 0);
        check("over_map_held", 32'(qhit), 32'd1);
        press_start();
        check("restart_clears_over", 32'(game_over), 32'd0);
        cycle();
        check("restart_map_cleared", 32'(qhit), 32'd0);

        // enb low freezes the count mid-move
        new_body(10, 10, m_pend);
        press_start();
        cycle();
        cycle();
        enb = 1'b0;
        vc = 0;
        repeat (100) begin
            cycle();
            vc += int'(valid);
        end
        check("frozen_no_valid", vc, 0);
        enb = 1'b1;
        wait_move(50, 1'b0, n);
        check("resume_latency", n, 3);

        // Reset during CHECK aborts the move
        do_reset();
        new_body(12, 12, RIGHT);
        press_start();
        repeat (4) cycle();
        rst = 1'b1;
        cycle();
        check("abort_no_valid", 32'(valid), 32'd0);
        rst = 1'b0;
        vc = 0;
        repeat (10) begin
            cycle();
            vc += int'(valid);
        end
        check("abort_stays_idle", vc, 0);

        // Randomized play against the model
        for (int c = 0; c < 2500; c++) begin
            start       = 1'b0;
            dir_req_vld = 1'b0;
            rst         = 1'b0;
            enb         = ($urandom_range(9) != 0);
            qx          = 5'($urandom_range(31));
            qy          = 5'($urandom_range(31));
            case (m_phase)
                P_IDLE: begin
                    if ($urandom_range(3) == 0) begin
                        new_body($urandom_range(COLS - 1), $urandom_range(ROWS - 1), m_pend);
                        start = 1'b1;
                    end
                end
                P_OVER: begin
                    if ($urandom_range(7) == 0) start = 1'b1;
                end
                default: begin
                    if ($urandom_range(9) == 0) begin
                        dir_req     = 2'($urandom_range(3));
                        dir_req_vld = 1'b1;
                    end
                    if ($urandom_range(29) == 0) food_ahead();
                    if ($urandom_range(299) == 0) rst = 1'b1;
                end
            endcase
            cycle();
        end
        start = 1'b0; dir_req_vld = 1'b0; rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
